// File: rtl/iter_alu_pkg.sv
// Shared definitions for iter_alu: funct3 codes, FSM state encodings and a
// width-generic two's-complement negate helper.
package iter_alu_pkg;

  localparam logic [2:0] ALU_ADD_SUB = 3'b000;
  localparam logic [2:0] ALU_SLL     = 3'b001;
  localparam logic [2:0] ALU_SLT     = 3'b010;
  localparam logic [2:0] ALU_SLTU    = 3'b011;
  localparam logic [2:0] ALU_XOR     = 3'b100;
  localparam logic [2:0] ALU_SRL_SRA = 3'b101;
  localparam logic [2:0] ALU_OR      = 3'b110;
  localparam logic [2:0] ALU_AND     = 3'b111;

  localparam logic [2:0] M_MUL    = 3'b000;
  localparam logic [2:0] M_MULH   = 3'b001;
  localparam logic [2:0] M_MULHSU = 3'b010;
  localparam logic [2:0] M_MULHU  = 3'b011;
  localparam logic [2:0] M_DIV    = 3'b100;
  localparam logic [2:0] M_DIVU   = 3'b101;
  localparam logic [2:0] M_REM    = 3'b110;
  localparam logic [2:0] M_REMU   = 3'b111;

  // Results are presented from S_IDLE so a new op can be accepted alongside out_ready;
  // S_BASE and S_DONE are reserved encodings that fall back to S_IDLE.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_BASE = 3'd1,
    S_MUL  = 3'd2,
    S_DIV  = 3'd3,
    S_FIX  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam int NEG_W = 128;

  function automatic logic [NEG_W-1:0] neg(input logic [NEG_W-1:0] x);
    return ~x + {{(NEG_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/iter_alu_divcore.sv
// Restoring-division datapath on unsigned magnitudes: one quotient bit per step.
// Only instantiated by iter_alu when ITER_ALU_DIV_EN is defined.
module iter_alu_divcore
  import iter_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem
);

  logic [XLEN-1:0] quo_r;
  logic [XLEN-1:0] rem_r;
  logic [XLEN-1:0] dsr_r;
  logic [XLEN:0]   shift_s;
  logic [XLEN:0]   diff_s;

  // Trial subtraction; bit XLEN of the difference set means the divisor did not fit.
  always_comb begin
    shift_s = {rem_r, quo_r[XLEN-1]};
    diff_s  = shift_s - {1'b0, dsr_r};
  end

  // Quotient bits shift into the vacated dividend register as it drains into the remainder.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      quo_r <= {XLEN{1'b0}};
      rem_r <= {XLEN{1'b0}};
      dsr_r <= {XLEN{1'b0}};
    end else if (load) begin
      quo_r <= dividend;
      rem_r <= {XLEN{1'b0}};
      dsr_r <= divisor;
    end else if (step) begin
      if (diff_s[XLEN]) begin
        rem_r <= shift_s[XLEN-1:0];
        quo_r <= {quo_r[XLEN-2:0], 1'b0};
      end else begin
        rem_r <= diff_s[XLEN-1:0];
        quo_r <= {quo_r[XLEN-2:0], 1'b1};
      end
    end
  end

  assign quo = quo_r;
  assign rem = rem_r;

endmodule

// File: rtl/iter_alu.sv
// Iterative RV32I/RV32M ALU: base ops in one cycle, multiply/divide one bit per cycle.
// Define ITER_ALU_DIV_EN to build the divider; otherwise DIV/REM ops return 0 after one cycle.
module iter_alu
  import iter_alu_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic            alt,
  input  logic            mext,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res,
  output logic            zero
);

  localparam int SH_W = $clog2(XLEN);
  localparam int W2   = 2 * XLEN;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]      op_r;
  logic [XLEN-1:0] mul_a_r;
  logic [W2-1:0]   acc_r;
  logic            neg_r;
  logic [XLEN-1:0] res_r;
  logic            zero_r;
  logic            out_valid_r;

  logic            in_ready_s;
  logic            accept_s;
  logic            mul_go_s;
  logic            div_go_s;
  logic [SH_W-1:0] shamt_s;
  logic [XLEN-1:0] base_res_s;
  logic            a_sgn_s;
  logic            b_sgn_s;
  logic            a_neg_s;
  logic            b_neg_s;
  logic [XLEN-1:0] mag_a_s;
  logic [XLEN-1:0] mag_b_s;
  logic [XLEN:0]   add_s;
  logic [W2-1:0]   acc_step_s;
  logic [W2-1:0]   prod_s;
  logic [XLEN-1:0] mul_res_s;
  logic [XLEN-1:0] quick_res_s;
  logic [XLEN-1:0] fix_res_s;

  assign in_ready_s = (state_r == S_IDLE) & (~out_valid_r | out_ready);
  assign accept_s   = in_valid & in_ready_s & ~kill;
  assign mul_go_s   = accept_s & mext & ~funct3[2];
  assign shamt_s    = srcb[SH_W-1:0];

  // Single-cycle base ALU on the live operands.
  always_comb begin
    base_res_s = {XLEN{1'b0}};
    case (funct3)
      ALU_ADD_SUB: if (alt) base_res_s = srca - srcb; else base_res_s = srca + srcb;
      ALU_SLL:     base_res_s = srca << shamt_s;
      ALU_SLT:     base_res_s = {{(XLEN-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      ALU_SLTU:    base_res_s = {{(XLEN-1){1'b0}}, (srca < srcb)};
      ALU_XOR:     base_res_s = srca ^ srcb;
      ALU_SRL_SRA: if (alt) base_res_s = $signed(srca) >>> shamt_s; else base_res_s = srca >> shamt_s;
      ALU_OR:      base_res_s = srca | srcb;
      ALU_AND:     base_res_s = srca & srcb;
      default:     base_res_s = {XLEN{1'b0}};
    endcase
  end

  // Operand signedness and magnitudes shared by the multiplier and divider.
  always_comb begin
    if (funct3[2]) begin
      a_sgn_s = ~funct3[0];
      b_sgn_s = ~funct3[0];
    end else begin
      a_sgn_s = (funct3[1:0] != 2'b11);
      b_sgn_s = ~funct3[1];
    end
    a_neg_s = a_sgn_s & srca[XLEN-1];
    b_neg_s = b_sgn_s & srcb[XLEN-1];
    if (a_neg_s) mag_a_s = XLEN'(neg(NEG_W'(srca))); else mag_a_s = srca;
    if (b_neg_s) mag_b_s = XLEN'(neg(NEG_W'(srcb))); else mag_b_s = srcb;
  end

  // Shift-add step: the multiplier sits in the low half and is consumed from bit 0.
  always_comb begin
    if (acc_r[0]) add_s = {1'b0, acc_r[W2-1:XLEN]} + {1'b0, mul_a_r};
    else add_s = {1'b0, acc_r[W2-1:XLEN]};
    acc_step_s = {add_s, acc_r[XLEN-1:1]};
    if (neg_r) prod_s = W2'(neg(NEG_W'(acc_r))); else prod_s = acc_r;
    if (op_r[1:0] == 2'b00) mul_res_s = prod_s[XLEN-1:0]; else mul_res_s = prod_s[W2-1:XLEN];
  end

`ifdef ITER_ALU_DIV_EN
  logic            div0_s;
  logic            ovf_s;
  logic            qneg_r;
  logic            rneg_r;
  logic [XLEN-1:0] quo_s;
  logic [XLEN-1:0] rem_s;

  // Divide-by-zero and min_int/-1 finish immediately without touching the divider.
  always_comb begin
    div0_s = (srcb == {XLEN{1'b0}});
    ovf_s  = ~funct3[0] & (srca == {1'b1, {(XLEN-1){1'b0}}}) & (srcb == {XLEN{1'b1}});
    if (div0_s) begin
      if (funct3[1]) quick_res_s = srca; else quick_res_s = {XLEN{1'b1}};
    end else if (funct3[1]) begin
      quick_res_s = {XLEN{1'b0}};
    end else begin
      quick_res_s = {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  assign div_go_s = accept_s & mext & funct3[2] & ~div0_s & ~ovf_s;

  iter_alu_divcore #(.XLEN(XLEN)) u_divcore (
    .clk      (clk),
    .rstn     (rstn),
    .load     (div_go_s),
    .step     ((state_r == S_DIV) & ~kill),
    .dividend (mag_a_s),
    .divisor  (mag_b_s),
    .quo      (quo_s),
    .rem      (rem_s)
  );

  // Result signs for the fix-up cycle: quotient follows sa^sb, remainder follows the dividend.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      qneg_r <= 1'b0;
      rneg_r <= 1'b0;
    end else if (div_go_s) begin
      qneg_r <= a_neg_s ^ b_neg_s;
      rneg_r <= a_neg_s;
    end
  end

  // Sign fix-up shared by the multiply and divide paths.
  always_comb begin
    if (!op_r[2]) fix_res_s = mul_res_s;
    else if (op_r[1]) fix_res_s = rneg_r ? XLEN'(neg(NEG_W'(rem_s))) : rem_s;
    else fix_res_s = qneg_r ? XLEN'(neg(NEG_W'(quo_s))) : quo_s;
  end
`else
  assign quick_res_s = {XLEN{1'b0}};
  assign div_go_s    = 1'b0;

  // Without the divider only the multiply path reaches the fix-up cycle.
  always_comb begin
    if (op_r[2]) fix_res_s = {XLEN{1'b0}};
    else fix_res_s = mul_res_s;
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_r <= S_IDLE;
    else state_r <= state_nxt_s;
  end

  // Next-state logic; kill overrides everything.
  always_comb begin
    state_nxt_s = state_r;
    if (kill) begin
      state_nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (mul_go_s) state_nxt_s = S_MUL;
          else if (div_go_s) state_nxt_s = S_DIV;
          else state_nxt_s = S_IDLE;
        end
        S_MUL, S_DIV: begin
          if (cnt_r == {CNT_W{1'b0}}) state_nxt_s = S_FIX;
          else state_nxt_s = state_r;
        end
        S_FIX:   state_nxt_s = S_IDLE;
        default: state_nxt_s = S_IDLE;
      endcase
    end
  end

  // Operand latching, iteration counter, accumulator and the registered result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r       <= {CNT_W{1'b0}};
      op_r        <= 3'b000;
      mul_a_r     <= {XLEN{1'b0}};
      acc_r       <= {W2{1'b0}};
      neg_r       <= 1'b0;
      res_r       <= {XLEN{1'b0}};
      zero_r      <= 1'b1;
      out_valid_r <= 1'b0;
    end else if (kill) begin
      cnt_r       <= {CNT_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      if (out_valid_r && out_ready) out_valid_r <= 1'b0;
      if (accept_s) begin
        op_r <= funct3;
        if (!mext) begin
          res_r       <= base_res_s;
          zero_r      <= (base_res_s == {XLEN{1'b0}});
          out_valid_r <= 1'b1;
        end else if (mul_go_s) begin
          mul_a_r <= mag_a_s;
          acc_r   <= {{XLEN{1'b0}}, mag_b_s};
          neg_r   <= a_neg_s ^ b_neg_s;
          cnt_r   <= CNT_W'(XLEN - 1);
        end else if (div_go_s) begin
          cnt_r <= CNT_W'(XLEN - 1);
        end else begin
          res_r       <= quick_res_s;
          zero_r      <= (quick_res_s == {XLEN{1'b0}});
          out_valid_r <= 1'b1;
        end
      end else begin
        case (state_r)
          S_MUL: begin
            acc_r <= acc_step_s;
            if (cnt_r != {CNT_W{1'b0}}) cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
          S_DIV: begin
            if (cnt_r != {CNT_W{1'b0}}) cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
          S_FIX: begin
            res_r       <= fix_res_s;
            zero_r      <= (fix_res_s == {XLEN{1'b0}});
            out_valid_r <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign res       = res_r;
  assign zero      = zero_r;

endmodule
